// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: the broadcast record, source
// naming and sizing constants.
// The record is the same one the reorder buffer consumes.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC = 5;
  localparam int ROB_ID_W    = 6;
  localparam int XLEN        = 32;

  typedef enum logic [2:0] {
    CDB_SRC_BR    = 3'd0,
    CDB_SRC_MEM   = 3'd1,
    CDB_SRC_ARITH = 3'd2,
    CDB_SRC_MULT  = 3'd3,
    CDB_SRC_DIV   = 3'd4
  } cdb_src_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] ROB_id;
    logic [XLEN-1:0]     data;
    logic                br_miss;
    logic                br_en;
    logic [XLEN-1:0]     pc_next;
    logic [XLEN-1:0]     mem_addr;
    logic [3:0]          mem_rmask;
    logic [3:0]          mem_wmask;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_rdata;
  } cdb_output_t;

  // Modular increment used to walk source indices around the ring.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO sitting between a functional unit and the CDB
// arbiter. Depth must be a power of two (>= 2) so the pointers wrap for
// free. A flush or reset empties it on the next edge; stored payloads are
// left in place because the count alone decides what is live.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  cdb_output_t push_data,
  input  logic        pop,
  output cdb_output_t head_data,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cdb_output_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && !rst && !flush;
  assign do_pop    = pop && !empty && !rst && !flush;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage write at the tail; payload needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers completed results from each functional
// unit and broadcasts one per cycle through a registered output.
// Build option CDB_RR_ARB_EN selects round-robin arbitration; without it the
// lowest source index (branch unit) always wins.
// fu_ready looks only at registered occupancy and rst/flush, so there is no
// combinational path from the grant logic back to the functional units.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = NUM_CDB_SRC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         fu_valid,
  output logic [NUM_SRC-1:0]         fu_ready,
  input  cdb_output_t [NUM_SRC-1:0]  fu_result,
  output cdb_output_t                cdb_out,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_push;
  logic [NUM_SRC-1:0] fifo_pop;
  cdb_output_t        head_data [NUM_SRC];
  cdb_output_t        granted;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic               take_grant;

  assign fu_ready   = ~fifo_full & {NUM_SRC{~rst & ~flush}};
  assign fifo_push  = fu_valid & fu_ready;
  assign take_grant = grant_valid && !rst && !flush;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    cdb_src_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (fifo_push[i]),
      .push_data(fu_result[i]),
      .pop      (fifo_pop[i]),
      .head_data(head_data[i]),
      .full     (fifo_full[i]),
      .empty    (fifo_empty[i])
    );
  end

`ifdef CDB_RR_ARB_EN
  logic [SRC_W-1:0] rr_ptr;
  int               probe;

  // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    probe       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      probe = wrap_add(int'(rr_ptr), k, NUM_SRC);
      if (!grant_valid && !fifo_empty[probe]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(probe);
      end
    end
  end

  // Advance the pointer past the winner; a flushed grant does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (take_grant) begin
      rr_ptr <= SRC_W'(wrap_add(int'(grant_idx), 1, NUM_SRC));
    end
  end
`else
  // Fixed priority: lowest-numbered non-empty FIFO wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!grant_valid && !fifo_empty[k]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(k);
      end
    end
  end
`endif

  // Pop only the winning FIFO, and only when the grant is really taken.
  always_comb begin
    fifo_pop = '0;
    if (take_grant) begin
      fifo_pop[grant_idx] = 1'b1;
    end
  end

  // Winning head with valid forced on; the payload is otherwise untouched.
  always_comb begin
    granted       = head_data[grant_idx];
    granted.valid = 1'b1;
  end

  // Broadcast register: idle cycles drop valid but keep the last payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_out <= '0;
      cdb_src <= '0;
    end else if (take_grant) begin
      cdb_out <= granted;
      cdb_src <= grant_idx;
    end else begin
      cdb_out.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_SRC 5, FIFO_DEPTH 2).
// Honours CDB_RR_ARB_EN: the shared vectors behave identically under both
// arbitration schemes; preemption/backpressure vectors apply to fixed
// priority, alternation vectors to round-robin.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  typedef struct {
    logic       rst;
    logic       flush;
    logic [4:0] valid;
    logic [5:0] base;
    logic [4:0] exp_ready;
    logic       exp_valid;
    logic [5:0] exp_rob;
    logic [2:0] exp_src;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [4:0]        fu_valid;
  logic [4:0]        fu_ready;
  cdb_output_t [4:0] fu_result;
  cdb_output_t       cdb_out;
  logic [2:0]        cdb_src;

  int   num_vectors = 0;
  int   miscompares = 0;
  vec_t vecs[$];

  cdb_arbiter #(
    .NUM_SRC   (5),
    .FIFO_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_ready (fu_ready),
    .fu_result(fu_result),
    .cdb_out  (cdb_out),
    .cdb_src  (cdb_src)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic [4:0] v,
                              input logic [5:0] b, input logic [4:0] er,
                              input logic ev, input logic [5:0] erob,
                              input logic [2:0] es);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.base = b;
    t.exp_ready = er; t.exp_valid = ev; t.exp_rob = erob; t.exp_src = es;
    return t;
  endfunction

  function automatic logic [31:0] tag_data(input logic [5:0] rob);
    return 32'hC0DE_0000 | {26'd0, rob};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act,
                             input logic [255:0] exp);
    num_vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check ready before the rising
  // edge, then check the registered broadcast just after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    cdb_output_t r;
    @(negedge clk);
    rst      = v.rst;
    flush    = v.flush;
    fu_valid = v.valid;
    for (int i = 0; i < 5; i++) begin
      r        = '0;
      r.valid  = v.valid[i];
      r.ROB_id = v.base + 6'(i);
      r.data   = tag_data(r.ROB_id);
      fu_result[i] = r;
    end
    #1;
    checkOutput($sformatf("v%0d fu_ready", idx), 256'(fu_ready), 256'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d valid", idx), 256'(cdb_out.valid), 256'(v.exp_valid));
    checkOutput($sformatf("v%0d ROB_id", idx), 256'(cdb_out.ROB_id), 256'(v.exp_rob));
    checkOutput($sformatf("v%0d cdb_src", idx), 256'(cdb_src), 256'(v.exp_src));
    if (v.exp_valid) begin
      checkOutput($sformatf("v%0d data", idx), 256'(cdb_out.data), 256'(tag_data(v.exp_rob)));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cdb_output_t full_rec;
    cdb_output_t exp_rec;

    rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_result = '0;

    // reset, then all five sources contend
    vecs.push_back(mk(1, 0, 5'b00000,  0, 5'b00000, 0,  0, 0));
    vecs.push_back(mk(1, 0, 5'b11111,  0, 5'b00000, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b11111, 20, 5'b11111, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 20, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 21, 1));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 22, 2));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 23, 3));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 24, 4));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 24, 4));
    // two results in every FIFO, then flush with a push in flight
    vecs.push_back(mk(0, 0, 5'b11111, 56, 5'b11111, 0, 24, 4));
    vecs.push_back(mk(0, 0, 5'b11111,  8, 5'b11111, 1, 56, 0));
    vecs.push_back(mk(0, 1, 5'b11111, 16, 5'b00000, 0, 56, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 56, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 56, 0));
    vecs.push_back(mk(0, 0, 5'b00010, 33, 5'b11111, 0, 56, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 34, 1));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 34, 1));
    // lone arith result: one cycle latency, then idle
    vecs.push_back(mk(0, 0, 5'b00100, 10, 5'b11111, 0, 34, 1));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 12, 2));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 12, 2));
    // reset while four results are buffered
    vecs.push_back(mk(0, 0, 5'b01111, 40, 5'b11111, 0, 12, 2));
    vecs.push_back(mk(1, 0, 5'b00000,  0, 5'b00000, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0,  0, 0));
`ifdef CDB_RR_ARB_EN
    // sources 0 and 4 stream; grants alternate
    vecs.push_back(mk(0, 0, 5'b10001,  0, 5'b11111, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b10001,  8, 5'b11111, 1,  0, 0));
    vecs.push_back(mk(0, 0, 5'b10001, 16, 5'b01111, 1,  4, 4));
    vecs.push_back(mk(0, 0, 5'b10001, 16, 5'b11110, 1,  8, 0));
    vecs.push_back(mk(0, 0, 5'b10001, 24, 5'b01111, 1, 12, 4));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11110, 1, 16, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 20, 4));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 24, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 24, 0));
`else
    // contention with a late br push preempting the rest
    vecs.push_back(mk(0, 0, 5'b11111, 20, 5'b11111, 0,  0, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 20, 0));
    vecs.push_back(mk(0, 0, 5'b00001, 30, 5'b11111, 1, 21, 1));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 30, 0));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 22, 2));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 23, 3));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 24, 4));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 24, 4));
    // br streams while mult fills up and has its third push held
    vecs.push_back(mk(0, 0, 5'b01001, 40, 5'b11111, 0, 24, 4));
    vecs.push_back(mk(0, 0, 5'b01001, 44, 5'b11111, 1, 40, 0));
    vecs.push_back(mk(0, 0, 5'b01001, 48, 5'b10111, 1, 44, 0));
    vecs.push_back(mk(0, 0, 5'b01000, 48, 5'b10111, 1, 48, 0));
    vecs.push_back(mk(0, 0, 5'b01000, 48, 5'b10111, 1, 43, 3));
    vecs.push_back(mk(0, 0, 5'b01000, 48, 5'b11111, 1, 47, 3));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 1, 51, 3));
    vecs.push_back(mk(0, 0, 5'b00000,  0, 5'b11111, 0, 51, 3));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
    end

    // Full-payload forwarding through the arith port.
    full_rec           = '0;
    full_rec.valid     = 1'b1;
    full_rec.ROB_id    = 6'd3;
    full_rec.data      = 32'h0000_1234;
    full_rec.br_miss   = 1'b1;
    full_rec.br_en     = 1'b1;
    full_rec.pc_next   = 32'h8000_0104;
    full_rec.mem_addr  = 32'h1000_0040;
    full_rec.mem_rmask = 4'hF;
    full_rec.mem_wmask = 4'h3;
    full_rec.mem_wdata = 32'hCAFE_F00D;
    full_rec.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    fu_valid = 5'b00100;
    fu_result = '0;
    fu_result[CDB_SRC_ARITH] = full_rec;
    @(posedge clk);
    #1;
    checkOutput("arith no bypass valid", 256'(cdb_out.valid), 256'(0));
    @(negedge clk);
    fu_valid = '0;
    fu_result = '0;
    @(posedge clk);
    #1;
    exp_rec = full_rec;
    checkOutput("arith full record", 256'(cdb_out), 256'(exp_rec));
    checkOutput("arith cdb_src", 256'(cdb_src), 256'(CDB_SRC_ARITH));
    @(posedge clk);
    #1;
    checkOutput("arith drop valid", 256'(cdb_out.valid), 256'(0));
    checkOutput("arith hold data", 256'(cdb_out.data), 256'(32'h0000_1234));
    checkOutput("arith hold src", 256'(cdb_src), 256'(CDB_SRC_ARITH));

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units and broadcasts exactly one per cycle on the common data bus. The bus feeds the reorder buffer, reservation stations and physical register file. Each functional-unit port has a small FIFO behind a valid/ready handshake, so a unit can retire a result even when the bus is busy. All buffered results are discarded on a mispredict flush.

## Interface
Parameters:
- NUM_SRC, 5 — number of functional-unit result ports. Index 0 br, 1 mem, 2 arith, 3 mult, 4 div.
- FIFO_DEPTH, 2 — entries per source FIFO; a power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  mispredict flush, pulse from commit.
- fu_valid  in  NUM_SRC  per-source result valid.
- fu_ready  out  NUM_SRC  per-source FIFO can accept.
- fu_result  in  NUM_SRC x cdb_output_t  per-source result payload.
- cdb_out  out  cdb_output_t  registered broadcast:
  - valid, ROB_id, data, br_miss, br_en, pc_next;
  - mem_addr, mem_rmask, mem_wmask, mem_wdata, mem_rdata.
- cdb_src  out  $clog2(NUM_SRC)  index of the source that drove the current cdb_out (debug/perf).

## Operation
- Push: in cycle N, a source whose fu_valid and fu_ready are both high has fu_result written to the tail of its FIFO.
- fu_ready[i] = (count[i] != FIFO_DEPTH) && !rst && !flush.
  - Depends only on registered count and control inputs.
  - Does not depend on same-cycle pops, so there is no combinational path from arbitration to ready.
- Arbitration: each cycle, the candidates are the sources whose FIFO is non-empty. One grant at most per cycle.
  - The granted FIFO head is popped and registered into cdb_out with valid = 1.
  - cdb_src is updated to the granted index.
- No candidate: cdb_out.valid <= 0. The other cdb_out fields and cdb_src hold their values; consumers must qualify on valid.
- No backpressure from consumers: a broadcast is always consumed.
- Payload is forwarded unmodified. mem_rdata masking and ROB readiness are handled downstream.
- Simultaneous push and pop on the same FIFO: count is unchanged. This is legal even when the FIFO is full, but ready stays low that cycle.
- The FIFO read/write pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- Flush: on the next edge all FIFO counts and pointers are zeroed and cdb_out.valid <= 0.
  - A push presented in the flush cycle is dropped.
  - A result that would have been granted in that cycle is discarded, not broadcast.
  - The arbitration pointer is unchanged.
- rst has priority over flush and clears everything. rst asserted mid-operation discards all buffered results.

## Timing
- Reset values:
  - cdb_out all fields 0, cdb_src 0, every count 0.
  - Round-robin pointer 0.
  - fu_ready 0 while rst is high, all 1 in the first cycle after rst deasserts.
- Latency: a result accepted in cycle N, with no competition, appears on cdb_out in cycle N+1 (registered output through an empty FIFO). There is no bypass.
- Throughput: one broadcast per cycle total. A single source with continuous input sustains one result per cycle.
- Flush in cycle N: cdb_out.valid is 0 in N+1, and fu_ready returns high in N+1.

## Configuration
- CDB_RR_ARB_EN defined: round-robin arbitration.
  - A pointer rr_ptr is kept. Search starts at rr_ptr and wraps.
  - After a grant to source g, rr_ptr <= (g+1) mod NUM_SRC. rr_ptr is unchanged when nothing is granted.
- CDB_RR_ARB_EN undefined: fixed priority, lowest index wins (br highest). rr_ptr is not instantiated.

## Structure
- In module_types: cdb_output_t (already shared with the reorder buffer), NUM_CDB_SRC, and the enum cdb_src_t giving source index names.
- One sub-module, cdb_src_fifo:
  - parameterised on FIFO_DEPTH;
  - ports: push/pop/flush, head data, count-derived full/empty;
  - instantiated NUM_SRC times with a generate loop.
- The arbiter and the output register live in cdb_arbiter.

## Test plan
- Single source: arith pushes ROB_id 3, data 0x1234 in cycle 5 -> cdb_out.valid = 1, ROB_id 3, data 0x1234, cdb_src 2 in cycle 6; valid 0 in cycle 7.
- Contention: all five sources push once in the same cycle.
  - With CDB_RR_ARB_EN: five consecutive broadcasts in order 0,1,2,3,4.
  - Without it: the same order; then a new br push during the sequence preempts the remaining sources.
- Backpressure: mult pushes on 3 consecutive cycles while higher-priority br streams continuously, fixed priority, FIFO_DEPTH 2 -> fu_ready[3] low after the second accept, and the third push is held until a mult pop frees a slot.
- Fairness: with CDB_RR_ARB_EN, sources 0 and 4 push continuously -> grants alternate 0,4,0,4; no source waits more than NUM_SRC-1 cycles.
- Flush: two results buffered in each FIFO plus a push in the flush cycle -> cdb_out.valid 0 in the following cycle, all counts 0, no stale ROB_id is ever broadcast.
- Reset mid-stream: rst asserted for one cycle while 4 results are buffered -> all outputs 0 in the next cycle and fu_ready all 1 the cycle after.
